csa_accum_seq: RTL and testbench
================================

CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 The block SHALL take parameter BW, default 16, as the input operand width.
REQ-002 The block SHALL take parameter GW, default 4, as the guard-bit count; accumulator width AW = BW+GW.
REQ-003 The block SHALL take parameter CW, default 4, as the beat-counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  BW  unsigned operand, zero-extended to AW.
REQ-009 in_last  input  1  qualifies the final beat of a packet.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  AW  packet sum, modulo 2^AW.
REQ-013 out_cnt  output  CW  number of beats accepted, saturating.
REQ-014 out_sat  output  1  beat count exceeded 2^CW-1.

Function
REQ-015 A beat SHALL transfer on a clock edge where in_valid and in_ready are both high.
REQ-016 The FSM SHALL have the states IDLE, ACC, RES_LO, RES_HI and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in RES_LO, RES_HI and DONE.
REQ-018 IDLE + beat: the sum vector S SHALL load in_data, the carry vector C SHALL load 0, and cnt SHALL load 1.
REQ-019 From IDLE + beat, the next state SHALL be RES_LO if in_last is high, else ACC.
REQ-020 ACC + beat: S and C SHALL update via a 3:2 carry-save step on (S, C, in_data), with the carries stored pre-shifted left by 1 and bit AW dropped.
REQ-021 ACC + beat: cnt SHALL increment, saturating at 2^CW-1.
REQ-022 ACC + beat: out_sat SHALL be set if cnt is already at 2^CW-1.
REQ-023 From ACC + beat, the next state SHALL be RES_LO if in_last is high; with no beat, the state SHALL remain ACC.
REQ-024 There SHALL be no carry-propagate addition in the ACC path; every beat SHALL be constant-time.
REQ-025 RES_LO SHALL register the low AW/2 bits of S+C and the carry-out of that half, then go to RES_HI.
REQ-026 RES_HI SHALL register the high bits of S+C plus the stored carry, assemble out_sum, then go to DONE.
REQ-027 Latency: with the last beat accepted at edge E0, out_valid SHALL rise after edge E0+2 (two edges after E0).
REQ-028 DONE: out_valid SHALL be 1, and out_sum, out_cnt and out_sat SHALL hold stable until out_ready is high.
REQ-029 DONE + out_ready: the FSM SHALL go to IDLE on that edge and out_valid SHALL drop.
REQ-030 out_valid SHALL be 0 in all states other than DONE.
REQ-031 out_sum, out_cnt and out_sat SHALL retain their last values outside DONE.
REQ-032 The IDLE load SHALL clear out_sat.
REQ-033 No back-to-back overlap: a beat presented during RES_LO, RES_HI or DONE SHALL stall and SHALL NOT be accepted.
REQ-034 in_last without in_valid SHALL be ignored.
REQ-035 in_data SHALL have no effect unless a beat transfers.

Reset
REQ-036 rst high SHALL immediately force the state to IDLE.
REQ-037 rst high SHALL immediately clear S, C, cnt, the low-half register and the stored carry.
REQ-038 rst high SHALL immediately force out_valid=0, out_sum=0, out_cnt=0 and out_sat=0.
REQ-039 While rst is high, in_ready SHALL be 0.
REQ-040 On the first edge after rst releases, in_ready SHALL be 1.
REQ-041 A reset asserted mid-packet (ACC or RES_*) SHALL discard the partial packet, and the next packet SHALL be uncontaminated.

Verification (BW=16, GW=4, CW=4)
REQ-042 Beats 3, 5, 7 (last) with out_ready=1 -> out_sum=0x0000F, out_cnt=3, out_sat=0; out_valid rises two edges after the third beat.
REQ-043 Single beat 0xFFFF with in_last in IDLE -> out_sum=0x0FFFF, out_cnt=1; the FSM passes through RES_LO and RES_HI only.
REQ-044 16 beats of 0xFFFF -> out_sum=0xFFFF0, out_cnt=15, out_sat=1.
REQ-045 17 beats of 0xFFFF (wrap) -> out_sum=0x0FFEF, out_cnt=15, out_sat=1.
REQ-046 Beats 1, 2 (last), then out_ready=0 for 5 cycles while in_valid=1 -> out_valid stays 1 with out_sum=0x00003, in_ready stays 0, no beat is consumed; after out_ready=1 the FSM returns to IDLE and the waiting beat is accepted next edge.
REQ-047 Reset asserted after 2 of 4 beats (0x1000 each), then a new packet 0x0002, 0x0003 (last) -> all outputs 0 during reset; the new result is out_sum=0x00005, out_cnt=2.

Source files
------------

// File: rtl/csa_accum_seq_if.sv
// Stream handshake bundle for the carry-save packet accumulator:
// operand beats in, one packet result out.
interface csa_accum_seq_if #(
    parameter int BW = 16,
    parameter int GW = 4,
    parameter int CW = 4
);
    localparam int AW = BW + GW;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_cnt;
    logic          out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_sat
    );
endinterface

// File: rtl/csa_accum_seq.sv
// Packet accumulator: constant-time carry-save accumulation per beat,
// then a two-cycle split carry-propagate resolve of S+C.
//
// state  | meaning
// IDLE   | waiting for first beat of a packet
// ACC    | accumulating beats in carry-save form
// RES_LO | resolve low half of S+C, keep its carry-out
// RES_HI | resolve high half, assemble result
// DONE   | result valid, held until out_ready
module csa_accum_seq #(
    parameter int BW = 16,
    parameter int GW = 4,
    parameter int CW = 4
) (
    input logic             clk,
    input logic             rst,
    csa_accum_seq_if.slave  bus
);
    localparam int AW = BW + GW;
    localparam int LW = AW / 2;
    localparam int HW = AW - LW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, ACC, RES_LO, RES_HI, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] sum_vec, carry_vec;
    logic [AW-1:0] data_ext, csa_sum, csa_maj;
    logic [CW-1:0] cnt, out_cnt_r;
    logic [LW-1:0] lo_sum;
    logic          lo_carry;
    logic [HW-1:0] hi_sum;
    logic [AW-1:0] out_sum_r;
    logic          out_sat_r;
    logic          in_ready_i;
    logic          beat;

    assign in_ready_i = !rst && (state == IDLE || state == ACC);
    assign beat       = bus.in_valid && in_ready_i;

    assign data_ext = AW'(bus.in_data);
    assign csa_sum  = sum_vec ^ carry_vec ^ data_ext;
    assign csa_maj  = (sum_vec & carry_vec) | (sum_vec & data_ext) | (carry_vec & data_ext);
    assign hi_sum   = sum_vec[AW-1:LW] + carry_vec[AW-1:LW] + HW'(lo_carry);

    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cnt   = out_cnt_r;
    assign bus.out_sat   = out_sat_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat) state_nxt = bus.in_last ? RES_LO : ACC;
            ACC:     if (beat && bus.in_last) state_nxt = RES_LO;
            RES_LO:  state_nxt = RES_HI;
            RES_HI:  state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_vec   <= '0;
            carry_vec <= '0;
            cnt       <= '0;
            lo_sum    <= '0;
            lo_carry  <= 1'b0;
            out_sum_r <= '0;
            out_cnt_r <= '0;
            out_sat_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        sum_vec   <= data_ext;
                        carry_vec <= '0;
                        cnt       <= CW'(1);
                        out_sat_r <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        sum_vec   <= csa_sum;
                        // carries pre-shifted; the bit leaving the top is modulo-dropped
                        carry_vec <= {csa_maj[AW-2:0], 1'b0};
                        if (cnt == CNT_MAX) begin
                            out_sat_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RES_LO: begin
                    {lo_carry, lo_sum} <= {1'b0, sum_vec[LW-1:0]} + {1'b0, carry_vec[LW-1:0]};
                end
                RES_HI: begin
                    out_sum_r <= {hi_sum, lo_sum};
                    out_cnt_r <= cnt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq: packet table plus hand-written
// back-pressure and mid-packet reset sequences.
module tb_csa_accum_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    csa_accum_seq_if #(.BW(16), .GW(4), .CW(4)) bus ();

    csa_accum_seq #(.BW(16), .GW(4), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          n;
        logic [15:0] base;
        logic [15:0] step;
        bit          bubble;
        logic [19:0] sum;
        logic [3:0]  cnt;
        logic        sat;
    } vec_t;

    vec_t vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns right after the edge on which the final beat transfers.
    task automatic send_beats(input int n, input logic [15:0] base, input logic [15:0] step,
                              input bit bubble, input bit last_on_final);
        logic [15:0] d;
        int waited;
        for (int i = 0; i < n; i++) begin
            if (bubble && (i % 2 == 1)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b1;
                bus.in_data  = 16'($urandom);
                @(posedge clk);
            end
            d = base + 16'(i) * step;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_last  = last_on_final && (i == n - 1);
            waited = 0;
            while (!bus.in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_accept: in_ready stayed 0, required 1");
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_result(input bit stall_valid, input logic [15:0] stall_data,
                               input logic [19:0] exp_sum, input logic [3:0] exp_cnt,
                               input logic exp_sat, input bit drain);
        @(negedge clk);
        bus.in_valid = stall_valid;
        bus.in_data  = stall_data;
        bus.in_last  = 1'b1;
        check("lat_e0_out_valid", 32'(bus.out_valid), 32'd0);
        check("lat_e0_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("lat_e1_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_e2_out_valid", 32'(bus.out_valid), 32'd1);
        check("out_sum", 32'(bus.out_sum), 32'(exp_sum));
        check("out_cnt", 32'(bus.out_cnt), 32'(exp_cnt));
        check("out_sat", 32'(bus.out_sat), 32'(exp_sat));
        if (drain) begin
            @(negedge clk);
            check("drain_out_valid", 32'(bus.out_valid), 32'd0);
            check("retain_out_sum", 32'(bus.out_sum), 32'(exp_sum));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{3,  16'h0003, 16'h0002, 1'b0, 20'h0000F, 4'd3,  1'b0};
        vecs[1] = '{1,  16'hFFFF, 16'h0000, 1'b0, 20'h0FFFF, 4'd1,  1'b0};
        vecs[2] = '{16, 16'hFFFF, 16'h0000, 1'b1, 20'hFFFF0, 4'd15, 1'b1};
        vecs[3] = '{4,  16'h1234, 16'h1111, 1'b1, 20'h0AF36, 4'd4,  1'b0};
        vecs[4] = '{17, 16'hFFFF, 16'h0000, 1'b0, 20'h0FFEF, 4'd15, 1'b1};
        vecs[5] = '{15, 16'hFFFF, 16'h0000, 1'b0, 20'hEFFF1, 4'd15, 1'b0};
        vecs[6] = '{2,  16'h0001, 16'h0001, 1'b1, 20'h00003, 4'd2,  1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            send_beats(vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].bubble, 1'b1);
            wait_result(1'b0, 16'h0, vecs[v].sum, vecs[v].cnt, vecs[v].sat, 1'b1);
        end

        // Result back-pressure with a beat waiting that must stall.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send_beats(2, 16'h0001, 16'h0001, 1'b0, 1'b1);
        wait_result(1'b1, 16'h0009, 20'h00003, 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_sum", 32'(bus.out_sum), 32'h3);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        wait_result(1'b0, 16'h0, 20'h00009, 4'd1, 1'b0, 1'b1);

        // Reset mid-packet, then a clean packet.
        send_beats(2, 16'h1000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("mid_rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        check("mid_rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
        send_beats(2, 16'h0002, 16'h0001, 1'b0, 1'b1);
        wait_result(1'b0, 16'h0, 20'h00005, 4'd2, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
